// File: rtl/conv_pkg.sv
// Shared definitions for the convolution MAC datapath.
// Provides the per-beat sideband record that travels with the data through
// every pipeline stage, a constant-foldable clog2, the end-to-end latency
// helper, and the lane-slice offset helper used to unpack lane buses.
package conv_pkg;

    // Control information that accompanies each beat down the pipeline.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic psum_en;
        logic relu_en;
    } side_t;

    // Ceiling log2, usable in constant (parameter) context.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Cycles from an accepted last beat to its out_valid pulse.
    function automatic int latency(input int lanes);
        return clog2(lanes) + 3;
    endfunction

    localparam int DEF_K       = 4;
    localparam int DEF_LATENCY = latency(DEF_K);

    // Low bit index of a lane inside a packed lane bus.
    function automatic int lane_lo(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/conv_mac_path_if.sv
// Handshake/data bundle of conv_mac_path.
// master: the environment (drives beats and returned partial sums).
// slave : the MAC datapath (drives psum_req, results and status).
interface conv_mac_path_if #(
    parameter int DW = 16,
    parameter int K  = 4,
    parameter int AW = 40
);
    logic            in_valid;
    logic            in_first;
    logic            in_last;
    logic [K*DW-1:0] in_fm_data;
    logic [K*DW-1:0] weight;
    logic            psum_en;
    logic            relu_en;
    logic            psum_req;
    logic [AW-1:0]   out_fm_rd_data;
    logic            out_valid;
    logic [AW-1:0]   out_fm_wr_data;
    logic            frame_err;
    logic [15:0]     kernel_cnt;

    modport master (
        output in_valid, in_first, in_last, in_fm_data, weight,
               psum_en, relu_en, out_fm_rd_data,
        input  psum_req, out_valid, out_fm_wr_data, frame_err, kernel_cnt
    );

    modport slave (
        input  in_valid, in_first, in_last, in_fm_data, weight,
               psum_en, relu_en, out_fm_rd_data,
        output psum_req, out_valid, out_fm_wr_data, frame_err, kernel_cnt
    );
endinterface

// File: rtl/conv_add_stage.sv
// One registered level of the pairwise adder tree.
// Ports: clk, rst (async active-low); din = N signed IW-bit values packed
// LSB-first; sin = incoming sideband. dout = N/2 signed (IW+1)-bit sums,
// sout = sideband delayed by one cycle. Data holds on bubbles.
module conv_add_stage
    import conv_pkg::*;
#(
    parameter int IW = 32,
    parameter int N  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N*IW-1:0]          din,
    input  side_t                    sin,
    output logic [(N/2)*(IW+1)-1:0]  dout,
    output side_t                    sout
);

    logic [(N/2)*(IW+1)-1:0] sum_s;

    // Sign-extend each neighbouring pair by one bit and add.
    always_comb begin
        sum_s = '0;
        for (int p = 0; p < N / 2; p++) begin
            sum_s[p*(IW+1) +: (IW+1)] =
                {din[(2*p)*IW + IW - 1],   din[(2*p)*IW +: IW]} +
                {din[(2*p+1)*IW + IW - 1], din[(2*p+1)*IW +: IW]};
        end
    end

    // Stage register: sideband always advances, data only on valid beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
            sout <= '0;
        end else begin
            sout <= sin;
            if (sin.valid) begin
                dout <= sum_s;
            end else begin
                dout <= dout;
            end
        end
    end

endmodule

// File: rtl/conv_mac_path.sv
// Convolution MAC datapath: K-lane signed multiply, registered adder tree,
// window accumulator, optional partial-sum add and ReLU.
// Ports: clk, rst (async active-low), bus (conv_mac_path_if.slave) carrying
// the beat handshake, psum read request/return, result and status outputs.
// A last beat accepted in cycle t gives psum_req at t+1+log2(K), samples the
// returned partial sum at the end of t+2+log2(K) and pulses out_valid at
// t+3+log2(K).
module conv_mac_path
    import conv_pkg::*;
#(
    parameter int DW = 16,
    parameter int K  = 4,
    parameter int AW = 40
) (
    input  logic           clk,
    input  logic           rst,
    conv_mac_path_if.slave bus
);

    localparam int L       = clog2(K);
    localparam int LAT     = latency(K);
    localparam int PW      = 2 * DW;
    localparam int SW      = PW + L;
    localparam int PRE_IDX = (L >= 2) ? (L - 2) : 0;

    logic            open_r;
    logic            frame_err_r;
    logic            accept_s;
    logic            err_s;
    logic [K*PW-1:0] prod_s;
    logic [K*PW-1:0] prod_r;
    side_t           side0_r;
    logic [SW-1:0]   tree_sum_s;
    side_t           tree_side_s;
    side_t           pre_side_s;
    logic [AW-1:0]   ext_s;
    logic [AW-1:0]   acc_r;
    logic            acc_done_r;
    logic            acc_psum_r;
    logic            acc_relu_r;
    logic            psum_req_r;
    logic [AW-1:0]   res_s;
    logic [AW-1:0]   out_data_r;
    logic            out_valid_r;
    logic [15:0]     kernel_cnt_r;

    // A beat enters only as a window opener or inside an open window; an
    // orphan beat or a re-opening first is flagged.
    always_comb begin
        accept_s = bus.in_valid & (bus.in_first | open_r);
        err_s    = bus.in_valid & ((~bus.in_first & ~open_r) | (bus.in_first & open_r));
    end

    // Window-open flag and one-cycle protocol error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            open_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= err_s;
            if (accept_s) begin
                open_r <= ~bus.in_last;
            end else begin
                open_r <= open_r;
            end
        end
    end

    for (genvar g = 0; g < K; g++) begin : g_lane
        assign prod_s[g*PW +: PW] =
            $signed(bus.in_fm_data[lane_lo(g, DW) +: DW]) *
            $signed(bus.weight[lane_lo(g, DW) +: DW]);
    end

    // Product register; sideband valid carries acceptance, not raw in_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_r  <= '0;
            side0_r <= '0;
        end else begin
            side0_r <= '{valid: accept_s, first: bus.in_first, last: bus.in_last,
                         psum_en: bus.psum_en, relu_en: bus.relu_en};
            if (accept_s) begin
                prod_r <= prod_s;
            end else begin
                prod_r <= prod_r;
            end
        end
    end

    for (genvar j = 0; j < L; j++) begin : tree
        localparam int IW = PW + j;
        localparam int N  = K >> j;
        logic [N*IW-1:0]          din;
        side_t                    sin;
        logic [(N/2)*(IW+1)-1:0]  dout;
        side_t                    sout;
        if (j == 0) begin : g_src_prod
            assign din = prod_r;
            assign sin = side0_r;
        end else begin : g_src_tree
            assign din = tree[j-1].dout;
            assign sin = tree[j-1].sout;
        end
        conv_add_stage #(.IW(IW), .N(N)) u_stage (
            .clk  (clk),
            .rst  (rst),
            .din  (din),
            .sin  (sin),
            .dout (dout),
            .sout (sout)
        );
    end

    assign tree_sum_s  = tree[L-1].dout;
    assign tree_side_s = tree[L-1].sout;
    assign ext_s       = AW'($signed(tree_sum_s));

    // psum_req is launched from the stage feeding the tree output so that it
    // leads the accumulator's final value by one cycle.
    if (L == 1) begin : g_pre_prod
        assign pre_side_s = side0_r;
    end else begin : g_pre_tree
        assign pre_side_s = tree[PRE_IDX].sout;
    end

    // Window accumulator (load on first, add otherwise, hold on bubbles)
    // and partial-sum request pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r      <= '0;
            acc_done_r <= 1'b0;
            acc_psum_r <= 1'b0;
            acc_relu_r <= 1'b0;
            psum_req_r <= 1'b0;
        end else begin
            acc_done_r <= tree_side_s.valid & tree_side_s.last;
            psum_req_r <= pre_side_s.valid & pre_side_s.last & pre_side_s.psum_en;
            if (tree_side_s.valid) begin
                acc_r      <= tree_side_s.first ? ext_s : (acc_r + ext_s);
                acc_psum_r <= tree_side_s.psum_en;
                acc_relu_r <= tree_side_s.relu_en;
            end else begin
                acc_r      <= acc_r;
                acc_psum_r <= acc_psum_r;
                acc_relu_r <= acc_relu_r;
            end
        end
    end

    // Final sum: optional returned partial sum, then optional ReLU clamp.
    always_comb begin
        res_s = acc_r + (acc_psum_r ? bus.out_fm_rd_data : {AW{1'b0}});
        if (acc_relu_r && res_s[AW-1]) begin
            res_s = '0;
        end else begin
            res_s = res_s;
        end
    end

    // Result register, result pulse and completed-kernel counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_r   <= '0;
            out_valid_r  <= 1'b0;
            kernel_cnt_r <= 16'd0;
        end else begin
            out_valid_r <= acc_done_r;
            if (acc_done_r) begin
                out_data_r   <= res_s;
                kernel_cnt_r <= kernel_cnt_r + 16'd1;
            end else begin
                out_data_r   <= out_data_r;
                kernel_cnt_r <= kernel_cnt_r;
            end
        end
    end

    assign bus.psum_req       = psum_req_r;
    assign bus.out_valid      = out_valid_r;
    assign bus.out_fm_wr_data = out_data_r;
    assign bus.frame_err      = frame_err_r;
    assign bus.kernel_cnt     = kernel_cnt_r;

endmodule

// File: doc/conv_mac_path.md
CONV_MAC_PATH -- requirements
Module: conv_mac_path

Interface
REQ-001 SHALL have parameter DW, default 16, signed fixed-point operand width.
REQ-002 SHALL have parameter K, default 4, lane count; legal values are powers of two, 2..16.
REQ-003 SHALL have parameter AW, default 40, accumulator/result width; AW >= 2*DW+log2(K).
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, lane beat valid.
REQ-007 SHALL have port in_first, input, 1, first beat of a kernel window.
REQ-008 SHALL have port in_last, input, 1, last beat of a kernel window.
REQ-009 SHALL have port in_fm_data, input, K*DW, lane i is bits [i*DW +: DW].
REQ-010 SHALL have port weight, input, K*DW, same lane packing.
REQ-011 SHALL have port psum_en, input, 1, add stored partial sum; sampled with in_last.
REQ-012 SHALL have port relu_en, input, 1, clamp negative results; sampled with in_last.
REQ-013 SHALL have port psum_req, output, 1, partial-sum read request pulse.
REQ-014 SHALL have port out_fm_rd_data, input, AW, partial sum returned one cycle after psum_req.
REQ-015 SHALL have port out_valid, output, 1, result pulse.
REQ-016 SHALL have port out_fm_wr_data, output, AW, result.
REQ-017 SHALL have port frame_err, output, 1, one-cycle protocol-error pulse.
REQ-018 SHALL have port kernel_cnt, output, 16, completed kernels, wraps at 2^16.

Function
REQ-019 SHALL register K signed products DW x DW -> 2*DW one cycle after an accepted beat.
REQ-020 SHALL reduce products through a registered adder tree of log2(K) stages, growing width by 1 bit per stage, then sign-extend to AW.
REQ-021 SHALL carry valid/first/last/psum_en/relu_en sidebands alongside the data through every pipeline stage.
REQ-022 SHALL have an accumulator stage that loads the tree sum on first, adds on non-first, and holds on bubbles; it wraps modulo 2^AW.
REQ-023 SHALL accept a beat only when in_valid=1 and either in_first=1 or a window is open.
REQ-024 SHALL open the window on an accepted first and close it on an accepted last; first&last in the same beat is a single-beat kernel.
REQ-025 SHALL treat in_valid beats with in_first=0 while no window is open as errors: drop the beat and pulse frame_err the next cycle.
REQ-026 SHALL treat in_first while a window is open as an error: discard the open window, pulse frame_err, and start the new window with this beat.
REQ-027 SHALL, for a last beat accepted in cycle t, pulse psum_req in cycle t+1+log2(K) only if psum_en=1.
REQ-028 SHALL, for a last beat accepted in cycle t, sample out_fm_rd_data at the end of cycle t+2+log2(K) when psum_en=1, else add zero.
REQ-029 SHALL, with relu_en=1, force negative sums to 0.
REQ-030 SHALL, for a last beat accepted in cycle t, assert out_valid in cycle t+3+log2(K) (latency 5 for K=4) for exactly one cycle.
REQ-031 SHALL hold out_fm_wr_data at its last value when out_valid=0.
REQ-032 SHALL increment kernel_cnt in the out_valid cycle.
REQ-033 SHALL sustain back-to-back kernels at full throughput (a new first directly after a last), with no bubble.

Reset
REQ-034 SHALL, while rst=0, asynchronously clear all sideband valids, the window-open flag, accumulator, kernel_cnt, out_fm_wr_data, out_valid, psum_req and frame_err to 0.
REQ-035 SHALL, on reset mid-window, lose the in-flight kernels and generate no out_valid for them after release.

Structure
REQ-036 SHALL place clog2 function, latency constant (log2(K)+3) and lane-slice helpers in shared package conv_pkg.
REQ-037 SHALL implement one registered pairwise-reduction level as sub-module conv_add_stage, instantiated log2(K) times via generate.

Verification
REQ-038 SHALL cover K=4, 1 beat first&last, data all 2, weights all 3, psum_en=0 -> out_valid at +5 cycles, result 24, kernel_cnt=1.
REQ-039 SHALL cover 3-beat window of lanes {1,-2,3,-4} x weights 1 with bubbles between beats -> result -6, single out_valid.
REQ-040 SHALL cover psum_en=1 with 24-type kernel and out_fm_rd_data=100 returned after psum_req -> result 124; psum_req exactly 1 cycle before sampling.
REQ-041 SHALL cover relu_en=1 with sum -6 -> result 0; relu_en=0 -> -6 (two's complement, AW bits).
REQ-042 SHALL cover a second first inside an open window -> frame_err pulse, only the new window's result emitted; an orphan non-first beat -> frame_err, no output.
REQ-043 SHALL cover rst=0 asserted mid-window for 1 cycle -> all outputs 0 immediately, no out_valid afterwards, next clean kernel correct.
